// File: rtl/mult_rr_scheduler.sv
// Round-robin arbiter sharing one Q10 multiplier among NUM_REQ requesters.
// Two-stage pipeline (operands, result) with a single backpressured response channel.
module mult_rr_scheduler #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [ID_W-1:0]               rsp_id,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          busy
);

   logic                  s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]       s1_id_q, s1_id_d;
   logic [DATA_WIDTH-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [ID_W-1:0]       s2_id_q, s2_id_d;
   logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
   logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

   logic                  advance;
   logic                  gnt_found;
   logic [ID_W-1:0]       gnt_id;
   logic [DATA_WIDTH-1:0] prod, prod_rnd, mul_res;

   assign advance = !s2_valid_q || rsp_ready;

   // Rotating priority search starting at rr_ptr.
   always_comb begin
      int idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % NUM_REQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (reset_n && advance && gnt_found) req_ready[gnt_id] = 1'b1;
   end

   // The low DATA_WIDTH bits of a product are identical for signed and unsigned
   // operands, so a plain multiply suffices; negatives get +1023 to truncate toward zero.
   always_comb begin
      prod     = s1_x_q * s1_y_q;
      prod_rnd = prod[DATA_WIDTH-1] ? prod + DATA_WIDTH'(1023) : prod;
      mul_res  = DATA_WIDTH'($signed(prod_rnd) >>> 10);
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_id_d    = s1_id_q;
      s1_x_d     = s1_x_q;
      s1_y_d     = s1_y_q;
      s2_valid_d = s2_valid_q;
      s2_id_d    = s2_id_q;
      s2_data_d  = s2_data_q;
      rr_ptr_d   = rr_ptr_q;
      if (advance) begin
         s2_valid_d = s1_valid_q;
         s2_id_d    = s1_id_q;
         s2_data_d  = mul_res;
         s1_valid_d = gnt_found;
         s1_id_d    = gnt_id;
         s1_x_d     = req_x[gnt_id*DATA_WIDTH +: DATA_WIDTH];
         s1_y_d     = req_y[gnt_id*DATA_WIDTH +: DATA_WIDTH];
         if (gnt_found)
            rr_ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_id_q    <= '0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s2_valid_q <= 1'b0;
         s2_id_q    <= '0;
         s2_data_q  <= '0;
         rr_ptr_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_id_q    <= s1_id_d;
         s1_x_q     <= s1_x_d;
         s1_y_q     <= s1_y_d;
         s2_valid_q <= s2_valid_d;
         s2_id_q    <= s2_id_d;
         s2_data_q  <= s2_data_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign rsp_valid = s2_valid_q;
   assign rsp_id    = s2_id_q;
   assign rsp_data  = s2_data_q;
   assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Bench for mult_rr_scheduler: vector table plus scoreboard of accepted requests,
// with hand sequences for round-robin order, backpressure, pointer and reset cases.
module tb_mult_rr_scheduler;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clock = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*DW-1:0] req_x, req_y;
   logic            rsp_valid, rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [DW-1:0]   rsp_data;
   logic            busy;

   mult_rr_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [IW-1:0] id;
      logic [DW-1:0] data;
   } rsp_t;

   typedef struct {
      int          req;
      logic [31:0] x;
      logic [31:0] y;
      logic [31:0] exp;
   } vec_t;

   rsp_t          sb[$];
   int            glog[$];
   int            checks = 0;
   int            failures = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data;
   logic [IW-1:0] prev_id;

   // Reference: truncating integer division matches Q10 round-toward-zero.
   function automatic logic [31:0] qmul(input logic [31:0] x, input logic [31:0] y);
      longint p;
      int     lo;
      p  = longint'(signed'(x)) * longint'(signed'(y));
      lo = int'(p[31:0]);
      return 32'(lo / 1024);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock: monitor at the falling edge, return just after the rising edge.
   task automatic step();
      rsp_t e;
      @(negedge clock);
      if (!reset_n) begin
         sb.delete();
         prev_stall = 1'b0;
      end else begin
         chk("grant_onehot", 32'($countones(req_ready) <= 1), 32'd1);
         if (rsp_valid && prev_stall) begin
            chk("stall_data", rsp_data, prev_data);
            chk("stall_id", 32'(rsp_id), 32'(prev_id));
         end
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected: got id=%0d data=0x%08h expected none", rsp_id, rsp_data);
            end else begin
               e = sb.pop_front();
               chk("sb_id", 32'(rsp_id), 32'(e.id));
               chk("sb_data", rsp_data, e.data);
            end
         end
         prev_stall = rsp_valid && !rsp_ready;
         prev_data  = rsp_data;
         prev_id    = rsp_id;
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               e.id   = IW'(i);
               e.data = qmul(req_x[i*DW +: DW], req_y[i*DW +: DW]);
               sb.push_back(e);
               glog.push_back(i);
            end
         end
         chk("inflight_le2", 32'(sb.size() <= 2), 32'd1);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && (busy || sb.size() != 0); k++) step();
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);
      chk("drain_idle", 32'(busy), 32'd0);
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         req_x[i*DW +: DW] = $urandom;
         req_y[i*DW +: DW] = $urandom_range(0, 32'h0000_3fff) - 32'h0000_2000;
      end
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{0, 32'h0000_0400, 32'h0000_0800, 32'h0000_0800};
      vecs[1] = '{1, 32'hFFFF_FC00, 32'h0000_0200, 32'hFFFF_FE00};
      vecs[2] = '{2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
      vecs[3] = '{3, 32'h0000_0600, 32'h0000_0600, 32'h0000_0900};
      vecs[4] = '{0, 32'hFFFF_F400, 32'h0000_0200, 32'hFFFF_FA00};
      vecs[5] = '{1, 32'hFFFF_FFFF, 32'h0000_07FF, 32'hFFFF_FFFF};
      vecs[6] = '{2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
      vecs[7] = '{3, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000};

      reset_n   = 1'b0;
      req_valid = '1;
      req_x     = '0;
      req_y     = '0;
      rsp_ready = 1'b1;
      step();
      step();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      req_valid = '0;
      reset_n   = 1'b1;
      step();

      // Table: single operations, latency and arithmetic
      foreach (vecs[v]) begin
         int n0;
         req_valid = '0;
         req_valid[vecs[v].req] = 1'b1;
         req_x[vecs[v].req*DW +: DW] = vecs[v].x;
         req_y[vecs[v].req*DW +: DW] = vecs[v].y;
         n0 = glog.size();
         step();
         chk("tbl_accept", 32'(glog.size()), 32'(n0 + 1));
         req_valid = '0;
         chk("tbl_no_early_rsp", 32'(rsp_valid), 32'd0);
         step();
         chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("tbl_data", rsp_data, vecs[v].exp);
         chk("tbl_id", 32'(rsp_id), 32'(vecs[v].req));
         step();
      end
      drain();

      // Round-robin order with every requester valid
      begin
         int n0;
         n0 = glog.size();
         req_valid = '1;
         for (int c = 0; c < 12; c++) begin
            rand_ops();
            step();
            if (c >= 1) chk("rr_no_gap", 32'(rsp_valid), 32'd1);
         end
         req_valid = '0;
         chk("rr_count", 32'(glog.size() - n0), 32'd12);
         for (int k = 0; k < 12; k++) chk("rr_order", 32'(glog[n0 + k]), 32'(k % N));
         drain();
      end

      // Backpressure: hold rsp_ready low with the pipeline full
      req_valid = '1;
      rand_ops();
      step();
      step();
      rsp_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_no_grant", 32'(req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
         rand_ops();
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      drain();

      // Pointer: req2 alone, then req0 and req3 together
      req_valid = 4'b0100;
      rand_ops();
      step();
      chk("ptr_first2", 32'(glog[$]), 32'd2);
      req_valid = 4'b1001;
      step();
      chk("ptr_then3", 32'(glog[$]), 32'd3);
      req_valid = 4'b0001;
      step();
      chk("ptr_then0", 32'(glog[$]), 32'd0);
      req_valid = '0;
      drain();

      // Reset with S1 and S2 both occupied
      req_valid = '1;
      rsp_ready = 1'b0;
      rand_ops();
      step();
      step();
      chk("rstmid_full", 32'(busy && rsp_valid), 32'd1);
      req_valid = 4'b1010;
      reset_n   = 1'b0;
      #1;
      chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_ready", 32'(req_ready), 32'd0);
      step();
      step();
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("rstmid_lowest", 32'(req_ready), 32'b0010);
      step();
      chk("rstmid_grant1", 32'(glog[$]), 32'd1);
      req_valid = '0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
